// File: rtl/ea_sample_buffer_if.sv
// Sample handshake bundle for the Error Analyzer capture stage:
// input side (read/expected pairs) and FWFT output side (stamped entries).
interface ea_sample_buffer_if #(
    parameter int DATA_W = 16,
    parameter int TS_W   = 64
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_read_i;
    logic [DATA_W-1:0] in_exp_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_read_o;
    logic [DATA_W-1:0] out_exp_o;
    logic [TS_W-1:0]   out_time_o;
    logic              out_mismatch_o;

    // Buffer side
    modport slave (
        input  in_valid_i, in_read_i, in_exp_i, out_ready_i,
        output in_ready_o, out_valid_o, out_read_o, out_exp_o, out_time_o, out_mismatch_o
    );

    // Producer/consumer side
    modport master (
        output in_valid_i, in_read_i, in_exp_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_read_o, out_exp_o, out_time_o, out_mismatch_o
    );
endinterface

// File: rtl/ea_sample_buffer.sv
// Error Analyzer sample buffer: stamps (read, expected) pairs with a
// free-running cycle timestamp, flags mismatches, buffers them in a
// first-word-fall-through FIFO and keeps saturating run statistics.
module ea_sample_buffer #(
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 16,
    parameter int TS_W         = 64,
    parameter int CNT_W        = 32,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     clear_i,
    ea_sample_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         sample_cnt_o,
    output logic [CNT_W-1:0]         mismatch_cnt_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     drained_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * DATA_W + TS_W + 1;

    localparam logic [AW:0]       PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]       FULL_LVL = {1'b1, {AW{1'b0}}};
    localparam logic [TS_W-1:0]   TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic              drained_q, drained_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [AW:0]       fill;
    logic              full;
    logic              empty;
    logic              in_ready;
    logic              accept;
    logic              write_en;
    logic              drop_en;
    logic              pop;
    logic              in_mismatch;
    logic [EW-1:0]     head;

    assign fill        = wptr_q - rptr_q;
    assign full        = (fill == FULL_LVL);
    assign empty       = (fill == '0);
    assign in_ready    = (state_q == ST_RUN) && (DROP_ON_FULL || !full);
    assign accept      = bus.in_valid_i && in_ready;
    // Full never bypasses: a pop in the same cycle does not make room.
    assign write_en    = accept && !full && !clear_i;
    assign drop_en     = accept && full && !clear_i;
    assign pop         = !empty && bus.out_ready_i;
    assign in_mismatch = (bus.in_read_i != bus.in_exp_i);
    assign head        = mem_q[rptr_q[AW-1:0]];

    // Capture-run state: IDLE -> RUN on enable, RUN -> DRAIN on disable, DRAIN -> IDLE once empty
    always_comb begin
        state_d   = state_q;
        drained_d = 1'b0;
        case (state_q)
            ST_IDLE:  if (enable_i) state_d = ST_RUN;
            ST_RUN:   if (!enable_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (empty) begin
                    state_d   = ST_IDLE;
                    drained_d = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // FIFO pointers/storage, timestamp and saturating statistics
    always_comb begin
        ts_d           = ts_q + TS_ONE;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        mem_d          = mem_q;
        overflow_d     = overflow_q;
        sample_cnt_d   = sample_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        if (clear_i) begin
            wptr_d         = '0;
            rptr_d         = '0;
            overflow_d     = 1'b0;
            sample_cnt_d   = '0;
            mismatch_cnt_d = '0;
            drop_cnt_d     = '0;
        end else begin
            if (pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            if (write_en) begin
                mem_d[wptr_q[AW-1:0]] = {bus.in_read_i, bus.in_exp_i, ts_q, in_mismatch};
                wptr_d = wptr_q + PTR_ONE;
                if (sample_cnt_q != CNT_MAX) sample_cnt_d = sample_cnt_q + CNT_ONE;
                if (in_mismatch && (mismatch_cnt_q != CNT_MAX)) begin
                    mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
                end
            end
            if (drop_en) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            drained_q      <= 1'b0;
            ts_q           <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            mem_q          <= '{default: '0};
            overflow_q     <= 1'b0;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            drained_q      <= drained_d;
            ts_q           <= ts_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            mem_q          <= mem_d;
            overflow_q     <= overflow_d;
            sample_cnt_q   <= sample_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign bus.in_ready_o     = in_ready;
    assign bus.out_valid_o    = !empty;
    assign bus.out_read_o     = head[EW-1 -: DATA_W];
    assign bus.out_exp_o      = head[EW-DATA_W-1 -: DATA_W];
    assign bus.out_time_o     = head[TS_W:1];
    assign bus.out_mismatch_o = head[0];

    assign fill_o         = fill;
    assign overflow_o     = overflow_q;
    assign sample_cnt_o   = sample_cnt_q;
    assign mismatch_cnt_o = mismatch_cnt_q;
    assign drop_cnt_o     = drop_cnt_q;
    assign drained_o      = drained_q;
endmodule
